tlb_lookup_arbiter: RTL and testbench

//  Shares the single search port of the unified TLB between the instruction-side and data-side
//  TLB buffers. Each buffer raises a lookup request on a buffer miss. The arbiter grants one

---
 rtl/tlb_lookup_arbiter.sv | 86 ++++++++
 tb/tb_tlb_lookup_arbiter.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/tlb_lookup_arbiter.sv
// tlb_lookup_arbiter: round-robin sharing of the unified TLB search port between the I-side and D-side buffers.
module tlb_lookup_arbiter #(
    parameter int VPN2_W  = 19,
    parameter int ENTRY_W = 78
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_req,
    input  logic [VPN2_W-1:0]  i_vpn2,
    output logic               i_ack,
    input  logic               d_req,
    input  logic [VPN2_W-1:0]  d_vpn2,
    output logic               d_ack,
    output logic [ENTRY_W-1:0] rsp_entry,
    output logic               rsp_found,
    input  logic               flush,
    input  logic               tlb_wr,
    output logic [VPN2_W-1:0]  tlb_s_vpn2,
    input  logic [ENTRY_W-1:0] tlb_s_entry,
    input  logic               tlb_s_found,
    output logic               busy
);
    typedef enum logic [1:0] {IDLE, LOOKUP, RESP} state_t;
    state_t r_state, w_next;
    // Last granted side (1 = D); it also names the owner of the transaction in flight.
    logic               r_last_d;
    logic [VPN2_W-1:0]  r_sel_vpn2;
    logic [ENTRY_W-1:0] r_entry;
    logic               r_found;
    logic               w_grant, w_grant_d, w_capture;
    always_comb begin
        w_next    = r_state;
        w_grant   = 1'b0;
        w_grant_d = 1'b0;
        w_capture = 1'b0;
        case (r_state)
            IDLE: if (!flush && !tlb_wr && (i_req || d_req)) begin
                w_grant   = 1'b1;
                w_grant_d = d_req && (!i_req || !r_last_d);
                w_next    = LOOKUP;
            end
            // A write this cycle may install the entry being searched, so search again.
            LOOKUP: if (flush) w_next = IDLE;
                    else if (!tlb_wr) begin
                        w_capture = 1'b1;
                        w_next    = RESP;
                    end
            RESP: begin
                w_next = IDLE;
                if (!flush && !tlb_wr && (r_last_d ? i_req : d_req)) begin
                    w_grant   = 1'b1;
                    w_grant_d = !r_last_d;
                    w_next    = LOOKUP;
                end
            end
            default: w_next = IDLE;
        endcase
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_last_d   <= 1'b1;
            r_sel_vpn2 <= '0;
            r_entry    <= '0;
            r_found    <= 1'b0;
        end else begin
            if (w_grant) begin
                r_last_d   <= w_grant_d;
                r_sel_vpn2 <= w_grant_d ? d_vpn2 : i_vpn2;
            end
            if (w_capture) begin
                r_entry <= tlb_s_entry;
                r_found <= tlb_s_found;
            end
        end
    end
    assign i_ack      = (r_state == RESP) && !r_last_d && !flush;
    assign d_ack      = (r_state == RESP) && r_last_d && !flush;
    assign rsp_entry  = r_entry;
    assign rsp_found  = r_found;
    assign tlb_s_vpn2 = r_sel_vpn2;
    assign busy       = r_state != IDLE;
endmodule

// File: tb/tb_tlb_lookup_arbiter.sv
// tb_tlb_lookup_arbiter: directed and random requests, expected acks queued by the driver and checked by a monitor.
module tb_tlb_lookup_arbiter;
    localparam int VW = 19;
    localparam int EW = 78;
    localparam int K_BUSY = 0, K_VPN = 1, K_FOUND = 2, K_ENTRY = 3, K_IACK = 4, K_DACK = 5;

    logic clk = 0, rst = 0, i_req = 0, d_req = 0, flush = 0, tlb_wr = 0;
    logic [VW-1:0] i_vpn2 = '0, d_vpn2 = '0;
    logic i_ack, d_ack, rsp_found, busy, tlb_s_found;
    logic [EW-1:0] rsp_entry, tlb_s_entry;
    logic [VW-1:0] tlb_s_vpn2;
    int cyc = 0, total = 0, bad = 0, tab_ver = 0;
    logic [EW-1:0] tab [logic [VW-1:0]];

    typedef struct { logic [EW-1:0] e; bit f; int at; int dl; } exp_t;
    typedef struct { int at; int k; logic [EW-1:0] v; } prb_t;
    exp_t qi[$], qd[$];
    prb_t pq[$], keep[$];

    tlb_lookup_arbiter dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_vpn2(i_vpn2), .i_ack(i_ack),
        .d_req(d_req), .d_vpn2(d_vpn2), .d_ack(d_ack),
        .rsp_entry(rsp_entry), .rsp_found(rsp_found),
        .flush(flush), .tlb_wr(tlb_wr),
        .tlb_s_vpn2(tlb_s_vpn2), .tlb_s_entry(tlb_s_entry), .tlb_s_found(tlb_s_found),
        .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural TLB array: same-cycle lookup of whatever the table holds now.
    always @(tlb_s_vpn2 or tab_ver) begin
        tlb_s_found = tab.exists(tlb_s_vpn2);
        tlb_s_entry = tlb_s_found ? tab[tlb_s_vpn2] : '0;
    end

    function automatic logic [EW-1:0] tl_e(input logic [VW-1:0] v);
        return tab.exists(v) ? tab[v] : '0;
    endfunction

    function automatic bit tl_f(input logic [VW-1:0] v);
        return tab.exists(v);
    endfunction

    function automatic logic [EW-1:0] obs(input int k);
        return k == K_BUSY ? EW'(busy) : k == K_VPN ? EW'(tlb_s_vpn2) : k == K_FOUND ? EW'(rsp_found) :
               k == K_ENTRY ? rsp_entry : k == K_IACK ? EW'(i_ack) : EW'(d_ack);
    endfunction

    function automatic string kname(input int k);
        return k == K_BUSY ? "busy" : k == K_VPN ? "tlb_s_vpn2" : k == K_FOUND ? "rsp_found" :
               k == K_ENTRY ? "rsp_entry" : k == K_IACK ? "i_ack" : "d_ack";
    endfunction

    task automatic check(input string n, input logic [EW-1:0] a, input logic [EW-1:0] x);
        total++;
        if (a !== x) begin
            bad++;
            $display("FAIL %s: actual=%h required=%h (cycle %0d)", n, a, x, cyc);
        end
    endtask

    task automatic got(input string s, input exp_t e);
        check({s, "_entry"}, rsp_entry, e.e);
        check({s, "_found"}, EW'(rsp_found), EW'(e.f));
        if (e.at >= 0) check({s, "_ack_cycle"}, EW'(cyc), EW'(e.at));
    endtask

    logic p_i_req = 0, p_d_req = 0, p_i_ack = 0, p_d_ack = 0, p_flush = 0, p_rst = 1;
    initial begin
        @(posedge clk);
        forever begin
            @(negedge clk);
            check("ack_exclusive", EW'(i_ack & d_ack), '0);
            if (flush) begin
                check("ack_during_flush", EW'(i_ack | d_ack), '0);
                qi.delete();
                qd.delete();
            end else begin
                if (i_ack) begin
                    if (qi.size() == 0) check("i_ack_spurious", EW'(i_ack), '0);
                    else got("i", qi.pop_front());
                end
                if (d_ack) begin
                    if (qd.size() == 0) check("d_ack_spurious", EW'(d_ack), '0);
                    else got("d", qd.pop_front());
                end
            end
            if (qi.size() > 0 && cyc > qi[0].dl) begin
                check("i_ack_timeout", EW'(cyc), EW'(qi[0].dl));
                void'(qi.pop_front());
            end
            if (qd.size() > 0 && cyc > qd[0].dl) begin
                check("d_ack_timeout", EW'(cyc), EW'(qd[0].dl));
                void'(qd.pop_front());
            end
            keep.delete();
            foreach (pq[n]) begin
                if (pq[n].at == cyc) check(kname(pq[n].k), obs(pq[n].k), pq[n].v);
                else if (pq[n].at < cyc) check("probe_missed", EW'(cyc), EW'(pq[n].at));
                else keep.push_back(pq[n]);
            end
            pq = keep;
            assert (rst || p_rst || !p_i_req || i_req || p_i_ack || p_flush)
                else $error("FAIL i_req dropped before ack");
            assert (rst || p_rst || !p_d_req || d_req || p_d_ack || p_flush)
                else $error("FAIL d_req dropped before ack");
            p_i_req = i_req; p_d_req = d_req; p_i_ack = i_ack; p_d_ack = d_ack;
            p_flush = flush; p_rst = rst;
        end
    end

    task automatic tick();
        logic ai, ad, fl;
        @(negedge clk);
        ai = i_ack; ad = d_ack; fl = flush;
        @(posedge clk);
        #1;
        flush = 0;
        if (ai || fl) i_req = 0;
        if (ad || fl) d_req = 0;
    endtask

    task automatic run(input int n);
        repeat (n) tick();
    endtask

    task automatic issue(input bit s, input logic [VW-1:0] v);
        if (s) begin d_vpn2 = v; d_req = 1; end
        else   begin i_vpn2 = v; i_req = 1; end
    endtask

    task automatic expect_ack(input bit s, input logic [EW-1:0] e, input bit f, input int at, input int dl);
        if (s) qd.push_back('{e, f, at, dl});
        else   qi.push_back('{e, f, at, dl});
    endtask

    task automatic expect_now(input bit s, input logic [VW-1:0] v, input int lat);
        expect_ack(s, tl_e(v), tl_f(v), cyc + lat, cyc + lat);
    endtask

    task automatic probe(input int at, input int k, input logic [EW-1:0] v);
        pq.push_back('{at, k, v});
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1);
    end

    initial begin
        logic [VW-1:0] vs [12];
        logic [VW-1:0] v;
        logic [EW-1:0] e1, e4;
        int c;
        for (int n = 0; n < 12; n++) vs[n] = VW'(n * 32'h1111 + 5);
        for (int n = 0; n < 8; n++) tab[vs[n]] = EW'({$urandom, $urandom, $urandom});
        e1 = 78'h2A5A50F0F0123456789A;
        e4 = EW'({$urandom, $urandom, $urandom});
        tab[19'h00400] = e1;
        tab[19'h12345] = EW'({$urandom, $urandom, $urandom});
        #1 rst = 1;
        repeat (2) @(posedge clk);
        #1;
        tab_ver++;
        for (int k = 0; k < 6; k++) probe(cyc, k, '0);
        tick();
        rst = 0;
        // I-side hit: ack two cycles after the request is seen
        c = cyc;
        issue(0, 19'h00400);
        expect_now(0, 19'h00400, 2);
        probe(c + 1, K_BUSY, 1);
        probe(c + 1, K_VPN, EW'(19'h00400));
        probe(c + 3, K_BUSY, 0);
        probe(c + 3, K_VPN, EW'(19'h00400));
        probe(c + 3, K_ENTRY, e1);
        probe(c + 3, K_FOUND, 1);
        run(4);
        // Both held from reset: I first, D granted straight from RESP
        rst = 1;
        issue(0, 19'h12345);
        issue(1, 19'h00400);
        tick();
        rst = 0;
        c = cyc;
        expect_now(0, 19'h12345, 2);
        expect_now(1, 19'h00400, 4);
        probe(c + 2, K_VPN, EW'(19'h12345));
        probe(c + 3, K_VPN, EW'(19'h00400));
        run(5);
        issue(1, vs[1]);
        expect_now(1, vs[1], 2);
        run(4);
        issue(0, vs[2]);
        issue(1, vs[3]);
        expect_now(0, vs[2], 2);
        expect_now(1, vs[3], 4);
        run(6);
        // D-side miss
        issue(1, 19'h0DEAD);
        expect_now(1, 19'h0DEAD, 2);
        probe(cyc + 3, K_FOUND, 0);
        run(4);
        // TLB write during LOOKUP installs the searched entry
        c = cyc;
        issue(1, 19'h7ABCD);
        expect_ack(1, e4, 1, c + 4, c + 4);
        tick();
        tlb_wr = 1;
        tick();
        tab[19'h7ABCD] = e4;
        tab_ver++;
        probe(cyc, K_BUSY, 1);
        probe(cyc, K_VPN, EW'(19'h7ABCD));
        tick();
        tlb_wr = 0;
        run(3);
        // Flush in LOOKUP, in RESP, and in IDLE alongside a request
        issue(0, vs[4]);
        tick();
        flush = 1;
        probe(cyc, K_BUSY, 1);
        tick();
        probe(cyc, K_BUSY, 0);
        run(2);
        issue(0, vs[5]);
        run(2);
        flush = 1;
        probe(cyc, K_IACK, 0);
        tick();
        probe(cyc, K_BUSY, 0);
        run(2);
        issue(0, vs[6]);
        flush = 1;
        probe(cyc + 1, K_BUSY, 0);
        tick();
        i_req = 1;
        expect_now(0, vs[6], 2);
        run(4);
        // Reset during RESP, then I must win the first post-reset grant
        issue(0, vs[7]);
        run(2);
        rst = 1;
        i_req = 0;
        for (int k = 0; k < 6; k++) probe(cyc, k, '0);
        tick();
        rst = 0;
        issue(0, vs[8]);
        issue(1, vs[0]);
        expect_now(0, vs[8], 2);
        expect_now(1, vs[0], 4);
        run(6);
        // Random traffic with sporadic writes and flushes
        for (int n = 0; n < 1500; n++) begin
            tick();
            flush = ($urandom_range(0, 29) == 0);
            tlb_wr = ($urandom_range(0, 5) == 0);
            if (!i_req && $urandom_range(0, 2) == 0) begin
                v = vs[$urandom_range(0, 11)];
                issue(0, v);
                expect_ack(0, tl_e(v), tl_f(v), -1, cyc + 100);
            end
            if (!d_req && $urandom_range(0, 2) == 0) begin
                v = vs[$urandom_range(0, 11)];
                issue(1, v);
                expect_ack(1, tl_e(v), tl_f(v), -1, cyc + 100);
            end
        end
        tick();
        tlb_wr = 0;
        run(120);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
